// File: rtl/i2s_tdm_tx_shifter_if.sv
// Sample stream into the TDM/I2S shifter: MSB-aligned 32-bit samples, valid/ready.
// Master drives data and valid; slave returns ready.
interface i2s_tdm_tx_shifter_if;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;

    modport master (output s_tdata, output s_tvalid, input  s_tready);
    modport slave  (input  s_tdata, input  s_tvalid, output s_tready);
endinterface

// File: rtl/i2s_tdm_tx_shifter.sv
// Serialises held samples MSB-first into TDM slots, one bit per bit_en; first bit one cycle after load strobe.
// One-entry hold register: s_tready drops while a sample is held; empty active slots are zero and flag underflow.
module i2s_tdm_tx_shifter #(
    parameter int SLOT_WIDTH = 32,
    parameter int TDM_MAX    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           valid_word_width_real,
    input  logic [3:0]           tdm_num,
    input  logic                 bit_en,
    input  logic                 frame_sync,
    i2s_tdm_tx_shifter_if.slave  s_if,
    output logic                 sdata,
    output logic                 underflow,
    output logic                 busy
);
    localparam int CNT_W = $clog2(SLOT_WIDTH);

    typedef enum logic [1:0] {IDLE, WAIT_SYNC, SHIFT} state_t;

    state_t                state_q, state_d;
    logic [SLOT_WIDTH-1:0] shift_reg_q, shift_reg_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [3:0]            slot_cnt_q, slot_cnt_d;
    logic [5:0]            width_l_q, width_l_d;
    logic [3:0]            tdm_l_q, tdm_l_d;
    logic [31:0]           hold_dat_q, hold_dat_d;
    logic                  hold_vld_q, hold_vld_d;
    logic                  underflow_q, underflow_d;
    logic                  busy_q, busy_d;

    logic        sync_stb;
    logic        slot_end;
    logic        hs;
    logic        do_load;
    logic [3:0]  tdm_clamped;
    logic [3:0]  tdm_eff;
    logic [5:0]  width_eff;
    logic [3:0]  slot_nxt;
    logic [31:0] width_mask;

    assign sync_stb      = bit_en && frame_sync;
    assign slot_end      = bit_en && (bit_cnt_q == CNT_W'(SLOT_WIDTH - 1));
    assign s_if.s_tready = !hold_vld_q && !rst;
    assign hs            = s_if.s_tvalid && s_if.s_tready;

    assign sdata     = shift_reg_q[SLOT_WIDTH-1];
    assign underflow = underflow_q;
    assign busy      = busy_q;

    always_comb begin
        tdm_clamped = tdm_num;
        if (tdm_num == 4'd0) begin
            tdm_clamped = 4'd1;
        end else if (tdm_num > 4'(TDM_MAX)) begin
            tdm_clamped = 4'(TDM_MAX);
        end
    end

    // A frame_sync load must use the config being latched on that same strobe.
    assign width_eff = sync_stb ? valid_word_width_real : width_l_q;
    assign tdm_eff   = sync_stb ? tdm_clamped : tdm_l_q;

    always_comb begin
        slot_nxt = 4'd0;
        if (!sync_stb) begin
            slot_nxt = (slot_cnt_q >= 4'(TDM_MAX)) ? 4'(TDM_MAX) : slot_cnt_q + 4'd1;
        end
    end

    always_comb begin
        width_mask = 32'hFFFF_FFFF;
        if (width_eff < 6'd32) begin
            width_mask = ~(32'hFFFF_FFFF >> width_eff);
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_reg_d = shift_reg_q;
        bit_cnt_d   = bit_cnt_q;
        slot_cnt_d  = slot_cnt_q;
        width_l_d   = width_l_q;
        tdm_l_d     = tdm_l_q;
        hold_dat_d  = hold_dat_q;
        hold_vld_d  = hold_vld_q;
        underflow_d = 1'b0;
        do_load     = 1'b0;

        if (sync_stb) begin
            width_l_d = valid_word_width_real;
            tdm_l_d   = tdm_clamped;
        end

        case (state_q)
            IDLE: begin
                shift_reg_d = '0;
                if (valid_word_width_real != 6'd0) begin
                    state_d = WAIT_SYNC;
                end
            end
            WAIT_SYNC: begin
                shift_reg_d = '0;
                if (valid_word_width_real == 6'd0) begin
                    state_d = IDLE;
                end else if (sync_stb) begin
                    state_d = SHIFT;
                    do_load = 1'b1;
                end
            end
            SHIFT: begin
                if (sync_stb && valid_word_width_real == 6'd0) begin
                    state_d     = IDLE;
                    shift_reg_d = '0;
                    bit_cnt_d   = '0;
                    slot_cnt_d  = 4'd0;
                end else if (sync_stb || slot_end) begin
                    do_load = 1'b1;
                end else if (bit_en) begin
                    shift_reg_d = {shift_reg_q[SLOT_WIDTH-2:0], 1'b0};
                    bit_cnt_d   = bit_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_load) begin
            bit_cnt_d  = '0;
            slot_cnt_d = slot_nxt;
            if (slot_nxt < tdm_eff) begin
                if (hold_vld_q) begin
                    shift_reg_d = SLOT_WIDTH'(hold_dat_q & width_mask) << (SLOT_WIDTH - 32);
                    hold_vld_d  = 1'b0;
                end else begin
                    shift_reg_d = '0;
                    underflow_d = 1'b1;
                end
            end else begin
                shift_reg_d = '0;
            end
        end

        // Applied after the consume so a same-cycle handshake refills the hold.
        if (hs) begin
            hold_dat_d = s_if.s_tdata;
            hold_vld_d = 1'b1;
        end

        busy_d = (state_d == SHIFT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_reg_q <= '0;
            bit_cnt_q   <= '0;
            slot_cnt_q  <= 4'd0;
            width_l_q   <= 6'd0;
            tdm_l_q     <= 4'd0;
            hold_dat_q  <= 32'd0;
            hold_vld_q  <= 1'b0;
            underflow_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_reg_q <= shift_reg_d;
            bit_cnt_q   <= bit_cnt_d;
            slot_cnt_q  <= slot_cnt_d;
            width_l_q   <= width_l_d;
            tdm_l_q     <= tdm_l_d;
            hold_dat_q  <= hold_dat_d;
            hold_vld_q  <= hold_vld_d;
            underflow_q <= underflow_d;
            busy_q      <= busy_d;
        end
    end
endmodule

// File: tb/tb_i2s_tdm_tx_shifter.sv
// Directed bench for i2s_tdm_tx_shifter: table of whole-frame vectors plus hand-written corner sequences.
module tb_i2s_tdm_tx_shifter;
    logic       clk;
    logic       rst;
    logic [5:0] valid_word_width_real;
    logic [3:0] tdm_num;
    logic       bit_en;
    logic       frame_sync;
    logic       sdata;
    logic       underflow;
    logic       busy;

    i2s_tdm_tx_shifter_if s_if ();

    i2s_tdm_tx_shifter #(.SLOT_WIDTH(32), .TDM_MAX(8)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .valid_word_width_real (valid_word_width_real),
        .tdm_num               (tdm_num),
        .bit_en                (bit_en),
        .frame_sync            (frame_sync),
        .s_if                  (s_if),
        .sdata                 (sdata),
        .underflow             (underflow),
        .busy                  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] src_q[$];
    bit feed_fire;

    typedef struct {
        logic [5:0]       width;
        logic [3:0]       tdm;
        int               nslots;
        int               nsamp;
        logic [0:8][31:0] samp;
        logic [0:8][31:0] exp_slot;
        logic [0:8]       exp_uf;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Source side: offers the queue head; pops once the handshake edge has passed.
    initial begin
        feed_fire      = 1'b0;
        s_if.s_tvalid  = 1'b0;
        s_if.s_tdata   = 32'd0;
        forever begin
            @(posedge clk);
            #2;
            if (feed_fire) void'(src_q.pop_front());
            s_if.s_tvalid = (src_q.size() != 0);
            s_if.s_tdata  = s_if.s_tvalid ? src_q[0] : 32'd0;
            feed_fire     = s_if.s_tvalid && s_if.s_tready;
        end
    end

    // One bit time: three quiet cycles, then a one-cycle strobe; outputs sampled 1ns after it.
    task automatic strobe(input logic fs, output logic sd, output logic uf);
        repeat (3) @(posedge clk);
        #1;
        bit_en     = 1'b1;
        frame_sync = fs;
        @(posedge clk);
        #1;
        bit_en     = 1'b0;
        frame_sync = 1'b0;
        sd = sdata;
        uf = underflow;
    endtask

    task automatic capture(input int n, input logic fs_first, output logic [31:0] w, output logic uf_any);
        logic sd, uf;
        w      = 32'd0;
        uf_any = 1'b0;
        for (int i = 0; i < n; i++) begin
            strobe(fs_first && (i == 0), sd, uf);
            w      = {w[30:0], sd};
            uf_any = uf_any | uf;
        end
    endtask

    initial begin
        logic [31:0] w, w2;
        logic        u;

        vecs[0] = '{6'd16, 4'd2, 2, 2,
                    {32'hA5A5_1234, 32'h3C3C_5678, 224'h0},
                    {32'hA5A5_0000, 32'h3C3C_0000, 224'h0}, 9'b0};
        vecs[1] = '{6'd24, 4'd1, 1, 1,
                    {32'hFFFF_FFFF, 256'h0}, {32'hFFFF_FF00, 256'h0}, 9'b0};
        vecs[2] = '{6'd32, 4'd1, 1, 1,
                    {32'hFFFF_FFFF, 256'h0}, {32'hFFFF_FFFF, 256'h0}, 9'b0};
        vecs[3] = '{6'd32, 4'd4, 4, 2,
                    {32'h1234_5678, 32'h9ABC_DEF0, 224'h0},
                    {32'h1234_5678, 32'h9ABC_DEF0, 224'h0}, 9'b0011_0000_0};
        vecs[4] = '{6'd24, 4'd3, 3, 3,
                    {32'h8000_0001, 32'h0000_FF80, 32'hC0FF_EE11, 192'h0},
                    {32'h8000_0000, 32'h0000_FF00, 32'hC0FF_EE00, 192'h0}, 9'b0};
        vecs[5] = '{6'd16, 4'd0, 1, 1,
                    {32'hDEAD_BEEF, 256'h0}, {32'hDEAD_0000, 256'h0}, 9'b0};
        vecs[6] = '{6'd32, 4'd9, 9, 8,
                    {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444,
                     32'h5555_5555, 32'h6666_6666, 32'h7777_7777, 32'h8888_8888, 32'h0},
                    {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444,
                     32'h5555_5555, 32'h6666_6666, 32'h7777_7777, 32'h8888_8888, 32'h0}, 9'b0};

        rst = 1'b1;
        valid_word_width_real = 6'd0;
        tdm_num    = 4'd0;
        bit_en     = 1'b0;
        frame_sync = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sdata", 32'(sdata), 32'd0);
        chk("rst_tready", 32'(s_if.s_tready), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("tready_after_rst", 32'(s_if.s_tready), 32'd1);

        for (int v = 0; v < 7; v++) begin
            valid_word_width_real = vecs[v].width;
            tdm_num               = vecs[v].tdm;
            for (int s = 0; s < vecs[v].nsamp; s++) src_q.push_back(vecs[v].samp[s]);
            for (int s = 0; s < vecs[v].nslots; s++) begin
                capture(32, s == 0, w, u);
                chk($sformatf("v%0d_slot%0d_data", v, s), w, vecs[v].exp_slot[s]);
                chk($sformatf("v%0d_slot%0d_uf", v, s), 32'(u), 32'(vecs[v].exp_uf[s]));
            end
        end
        chk("busy_in_shift", 32'(busy), 32'd1);

        // Early frame_sync at bit 10 of slot 1 truncates it and restarts at slot 0.
        valid_word_width_real = 6'd16;
        tdm_num               = 4'd2;
        src_q.push_back(32'hAAAA_1111);
        src_q.push_back(32'h5555_2222);
        src_q.push_back(32'hF0F0_3333);
        capture(32, 1'b1, w, u);
        chk("early_slot0", w, 32'hAAAA_0000);
        capture(10, 1'b0, w, u);
        chk("early_partial", w, 32'h0000_0155);
        capture(32, 1'b1, w, u);
        chk("early_resync_slot0", w, 32'hF0F0_0000);
        chk("early_resync_uf", 32'(u), 32'd0);
        capture(32, 1'b0, w, u);
        chk("early_slot1_data", w, 32'd0);
        chk("early_slot1_uf", 32'(u), 32'd1);

        // Width change mid-frame only applies from the next frame_sync.
        src_q.push_back(32'h1234_ABCD);
        src_q.push_back(32'h5678_EF01);
        src_q.push_back(32'h9ABC_2345);
        src_q.push_back(32'hDEF0_6789);
        capture(5, 1'b1, w, u);
        valid_word_width_real = 6'd32;
        capture(27, 1'b0, w2, u);
        chk("wchg_a_slot0", {w[4:0], w2[26:0]}, 32'h1234_0000);
        capture(32, 1'b0, w, u);
        chk("wchg_a_slot1", w, 32'h5678_0000);
        capture(32, 1'b1, w, u);
        chk("wchg_b_slot0", w, 32'h9ABC_2345);
        capture(32, 1'b0, w, u);
        chk("wchg_b_slot1", w, 32'hDEF0_6789);

        // Width 0 latched at the frame boundary returns to IDLE; hold stays full.
        valid_word_width_real = 6'd0;
        src_q.push_back(32'h7777_7777);
        repeat (3) @(posedge clk);
        #1;
        chk("w0_tready_hold_full", 32'(s_if.s_tready), 32'd0);
        capture(1, 1'b1, w, u);
        chk("w0_busy", 32'(busy), 32'd0);
        chk("w0_sdata", w, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        chk("w0_idle_busy", 32'(busy), 32'd0);
        chk("w0_idle_tready", 32'(s_if.s_tready), 32'd0);

        // Reset mid-slot with the hold full discards the held sample.
        valid_word_width_real = 6'd32;
        tdm_num               = 4'd1;
        src_q.push_back(32'h1212_1212);
        capture(6, 1'b1, w, u);
        chk("pre_rst_bits", w, 32'h0000_001D);
        chk("pre_rst_tready", 32'(s_if.s_tready), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_sdata", 32'(sdata), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_tready", 32'(s_if.s_tready), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_rel_tready", 32'(s_if.s_tready), 32'd1);

        // bit_en without frame_sync in WAIT_SYNC is ignored.
        capture(3, 1'b0, w, u);
        chk("wait_sync_sdata", w, 32'd0);
        chk("wait_sync_uf", 32'(u), 32'd0);
        chk("wait_sync_busy", 32'(busy), 32'd0);
        capture(32, 1'b1, w, u);
        chk("post_rst_slot_data", w, 32'd0);
        chk("post_rst_slot_uf", 32'(u), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
